// File: rtl/input_conditioner.sv
// Four-channel input front end: two-flop synchronizer, per-channel debounce
// counter, and a level or rising-edge pulse presentation of each clean input.
module input_conditioner #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned PULSE_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw,
    output logic       X1,
    output logic       X2,
    output logic       X3,
    output logic       X4,
    output logic       changed,
    output logic       stable
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] pls;
    logic [CW-1:0]  cnt [NCH];

    logic [NCH-1:0] lvl_nxt;
    logic [CW-1:0]  cnt_nxt [NCH];

    // Debounce decision: flip the clean level only after a full run of disagreement.
    always_comb begin
        lvl_nxt = lvl;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != lvl[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    lvl_nxt[i] = s2[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Synchronizer, debounce state, pulse and change strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            lvl     <= '0;
            pls     <= '0;
            changed <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            lvl     <= lvl_nxt;
            pls     <= lvl_nxt & ~lvl;
            changed <= |(lvl_nxt ^ lvl);
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Stable when no channel is mid-count; decoded from counter registers only.
    always_comb begin
        stable = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cnt[i] != '0) begin
                stable = 1'b0;
            end
        end
    end

    // Output format selection; both sources are registers.
    assign X1 = (PULSE_MODE != 0) ? pls[0] : lvl[0];
    assign X2 = (PULSE_MODE != 0) ? pls[1] : lvl[1];
    assign X3 = (PULSE_MODE != 0) ? pls[2] : lvl[2];
    assign X4 = (PULSE_MODE != 0) ? pls[3] : lvl[3];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: level, pulse and fast-debounce instances
// share one stimulus stream.
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] raw;

    logic l_x1, l_x2, l_x3, l_x4, l_chg, l_stb;
    logic p_x1, p_x2, p_x3, p_x4, p_chg, p_stb;
    logic f_x1, f_x2, f_x3, f_x4, f_chg, f_stb;

    int errors = 0;
    int checks = 0;

    input_conditioner #(.DB_CYCLES(4), .PULSE_MODE(0)) u_lvl (
        .clk(clk), .rst(rst), .raw(raw),
        .X1(l_x1), .X2(l_x2), .X3(l_x3), .X4(l_x4),
        .changed(l_chg), .stable(l_stb)
    );

    input_conditioner #(.DB_CYCLES(4), .PULSE_MODE(1)) u_pls (
        .clk(clk), .rst(rst), .raw(raw),
        .X1(p_x1), .X2(p_x2), .X3(p_x3), .X4(p_x4),
        .changed(p_chg), .stable(p_stb)
    );

    input_conditioner #(.DB_CYCLES(1), .PULSE_MODE(0)) u_fast (
        .clk(clk), .rst(rst), .raw(raw),
        .X1(f_x1), .X2(f_x2), .X3(f_x3), .X4(f_x4),
        .changed(f_chg), .stable(f_stb)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Directed sequence; edge numbers in tags count from the raw change.
    initial begin
        rst = 1'b1;
        raw = 4'b1111;

        // Reset held with all inputs high.
        tick(3);
        chk("rst_x1", l_x1, 1'b0);
        chk("rst_x2", l_x2, 1'b0);
        chk("rst_x3", l_x3, 1'b0);
        chk("rst_x4", l_x4, 1'b0);
        chk("rst_changed", l_chg, 1'b0);
        chk("rst_stable", l_stb, 1'b1);
        chk("rst_pls_x1", p_x1, 1'b0);
        raw = 4'b0000;
        tick(1);
        rst = 1'b0;

        // Clean rise on raw[0].
        raw = 4'b0001;
        tick(2);
        chk("rise_e2_stable", l_stb, 1'b1);
        chk("rise_e2_fast_x1", f_x1, 1'b0);
        tick(1);
        chk("rise_e3_stable", l_stb, 1'b0);
        chk("rise_e3_fast_x1", f_x1, 1'b1);
        chk("rise_e3_fast_chg", f_chg, 1'b1);
        tick(2);
        chk("rise_e5_x1", l_x1, 1'b0);
        chk("rise_e5_stable", l_stb, 1'b0);
        chk("rise_e5_changed", l_chg, 1'b0);
        tick(1);
        chk("rise_e6_x1", l_x1, 1'b1);
        chk("rise_e6_changed", l_chg, 1'b1);
        chk("rise_e6_stable", l_stb, 1'b1);
        chk("rise_e6_pls_x1", p_x1, 1'b1);
        tick(1);
        chk("rise_e7_x1", l_x1, 1'b1);
        chk("rise_e7_changed", l_chg, 1'b0);
        chk("rise_e7_pls_x1", p_x1, 1'b0);

        // Bounce on raw[1]: 3-cycle phases are shorter than the debounce window.
        for (int ph = 0; ph < 4; ph++) begin
            raw[1] = (ph % 2 == 0) ? 1'b1 : 1'b0;
            repeat (3) begin
                tick(1);
                chk("bounce_x2", l_x2, 1'b0);
                chk("bounce_changed", l_chg, 1'b0);
            end
        end
        raw[1] = 1'b1;
        tick(5);
        chk("bounce_e5_x2", l_x2, 1'b0);
        tick(1);
        chk("bounce_e6_x2", l_x2, 1'b1);
        chk("bounce_e6_changed", l_chg, 1'b1);

        // Pulse mode: raw[2] high for 20 cycles then low.
        raw[2] = 1'b1;
        tick(5);
        chk("pulse_e5_x3", p_x3, 1'b0);
        tick(1);
        chk("pulse_e6_x3", p_x3, 1'b1);
        chk("pulse_e6_changed", p_chg, 1'b1);
        for (int e = 7; e <= 20; e++) begin
            tick(1);
            chk("pulse_hold_x3", p_x3, 1'b0);
        end
        raw[2] = 1'b0;
        tick(5);
        chk("fall_e5_lvl_x3", l_x3, 1'b1);
        chk("fall_e5_changed", p_chg, 1'b0);
        tick(1);
        chk("fall_e6_pls_x3", p_x3, 1'b0);
        chk("fall_e6_changed", p_chg, 1'b1);
        chk("fall_e6_lvl_x3", l_x3, 1'b0);
        tick(1);
        chk("fall_e7_changed", p_chg, 1'b0);

        // Drop raw[0] and let it settle before the simultaneous rise.
        raw[0] = 1'b0;
        tick(8);
        chk("settle_x1", l_x1, 1'b0);

        // Simultaneous rise on raw[0] and raw[3].
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        tick(5);
        chk("simul_e5_x1", l_x1, 1'b0);
        chk("simul_e5_x4", l_x4, 1'b0);
        tick(1);
        chk("simul_e6_x1", l_x1, 1'b1);
        chk("simul_e6_x4", l_x4, 1'b1);
        chk("simul_e6_changed", l_chg, 1'b1);
        chk("simul_e6_pls_x1", p_x1, 1'b1);
        chk("simul_e6_pls_x4", p_x4, 1'b1);
        tick(1);
        chk("simul_e7_changed", l_chg, 1'b0);
        chk("simul_e7_pls_x4", p_x4, 1'b0);

        // Drop raw[3] and settle, then reset in the middle of its next rise.
        raw[3] = 1'b0;
        tick(8);
        chk("settle_x4", l_x4, 1'b0);
        raw[3] = 1'b1;
        tick(4);
        chk("midrst_cnt2_stable", l_stb, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("midrst_x1", l_x1, 1'b0);
        chk("midrst_x2", l_x2, 1'b0);
        chk("midrst_x4", l_x4, 1'b0);
        chk("midrst_stable", l_stb, 1'b1);
        chk("midrst_changed", l_chg, 1'b0);
        rst = 1'b0;
        tick(5);
        chk("post_e5_x4", l_x4, 1'b0);
        tick(1);
        chk("post_e6_x4", l_x4, 1'b1);
        chk("post_e6_x1", l_x1, 1'b1);
        chk("post_e6_changed", l_chg, 1'b1);
        chk("post_e6_pls_x1", p_x1, 1'b1);
        chk("post_e6_pls_x4", p_x4, 1'b1);
        tick(1);
        chk("post_e7_pls_x4", p_x4, 1'b0);
        chk("post_e7_x4", l_x4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
